// File: rtl/qam_pkg.sv
// Shared definitions for the CIC x8 interpolator rate sequencer: rate codes,
// sequencer states and the rate-to-decimation-exponent helper.
package qam_pkg;

  localparam logic [1:0] RATE_9600  = 2'b00;
  localparam logic [1:0] RATE_19200 = 2'b01;
  localparam logic [1:0] RATE_38400 = 2'b10;
  localparam logic [1:0] RATE_76800 = 2'b11;

  localparam int BASE_DIV_DEF = 18;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Slower rates stretch the CIC period by 2^k base periods.
  function automatic logic [1:0] rate_to_k(input logic [1:0] rate);
    return 2'd3 - rate;
  endfunction

endpackage

// File: rtl/cic_ce_gen.sv
// Clock-enable generator: prescaler, rate counter and symbol phase producing
// registered cic_ce (8x baud) and filt_ce (baud) strobes.
module cic_ce_gen
  import qam_pkg::*;
#(
  parameter int BASE_DIV = BASE_DIV_DEF,
  parameter int PRE_W    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run_en,
  input  logic       filt_en,
  input  logic [1:0] k,
  output logic       cic_ce,
  output logic       filt_ce,
  output logic [2:0] phase
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_AHEAD = PRE_W'(BASE_DIV - 2);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             cic_ce_q, cic_ce_d;
  logic             filt_ce_q, filt_ce_d;
  logic [2:0]       mask;
  logic             tick;

  // Strobes are decided one cycle early (pre one short of wrap) so the
  // registered cic_ce lands exactly on the tick cycle.
  always_comb begin
    mask      = 3'((4'd1 << k) - 4'd1);
    tick      = run_en && (pre_q == PRE_LAST);
    pre_d     = pre_q;
    rcnt_d    = rcnt_q;
    phase_d   = phase_q;
    cic_ce_d  = 1'b0;
    filt_ce_d = 1'b0;
    if (clear) begin
      pre_d   = '0;
      rcnt_d  = '0;
      phase_d = '0;
    end else if (run_en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        rcnt_d = rcnt_q + 3'd1;
      end
      if (cic_ce_q) begin
        phase_d = phase_q + 3'd1;
      end
      cic_ce_d  = (pre_q == PRE_AHEAD) && ((rcnt_q & mask) == mask);
      filt_ce_d = cic_ce_d && (phase_q == 3'd0) && filt_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      rcnt_q    <= '0;
      phase_q   <= '0;
      cic_ce_q  <= 1'b0;
      filt_ce_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      rcnt_q    <= rcnt_d;
      phase_q   <= phase_d;
      cic_ce_q  <= cic_ce_d;
      filt_ce_q <= filt_ce_d;
    end
  end

  assign cic_ce  = cic_ce_q;
  assign filt_ce = filt_ce_q;
  assign phase   = phase_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate sequencer for the I/Q CIC x8 interpolators: strobe generation plus a
// safe baud-rate change (drain to symbol end, zero flush, CIC reset, resume).
module cic_rate_ctrl
  import qam_pkg::*;
#(
  parameter int BASE_DIV      = BASE_DIV_DEF,
  parameter int FLUSH_SAMPLES = 16,
  parameter int CLEAR_CYCLES  = 2,
  parameter int PRE_W         = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_rate,
  output logic       cfg_ready,
  output logic       cic_ce,
  output logic       filt_ce,
  output logic       data_gate,
  output logic       cic_sync_rst,
  output logic [1:0] active_rate,
  output logic       busy,
  output state_e     dbg_state
);

  localparam int FC_W = $clog2(FLUSH_SAMPLES) + 1;
  localparam int CC_W = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_SAMPLES - 1);
  localparam logic [CC_W-1:0] CLEAR_LAST = CC_W'(CLEAR_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      rate_q, rate_d;
  logic [1:0]      pend_q, pend_d;
  logic [FC_W-1:0] flush_q, flush_d;
  logic [CC_W-1:0] clr_q, clr_d;
  logic            cfg_ready_q, busy_q, data_gate_q, cic_sync_rst_q;
  logic            accept;
  logic            gen_cic_ce;
  logic            gen_filt_ce;
  logic [2:0]      gen_phase;

  cic_ce_gen #(
    .BASE_DIV(BASE_DIV),
    .PRE_W   (PRE_W)
  ) u_ce_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == CLEAR),
    .run_en (state_q != CLEAR),
    .filt_en(state_d != FLUSH),
    .k      (rate_to_k(rate_q)),
    .cic_ce (gen_cic_ce),
    .filt_ce(gen_filt_ce),
    .phase  (gen_phase)
  );

  // Handshake: a request transfers on any cycle with cfg_valid && cfg_ready;
  // cfg_ready is registered and high only while in RUN, so a request held
  // across a rate change is taken on the first RUN cycle after it.
  assign accept = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    pend_d  = pend_q;
    flush_d = flush_q;
    clr_d   = clr_q;
    case (state_q)
      CLEAR: begin
        if (clr_q == CLEAR_LAST) begin
          state_d = RUN;
          rate_d  = pend_q;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      RUN: begin
        if (accept && (cfg_rate != rate_q)) begin
          pend_d  = cfg_rate;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (gen_cic_ce && (gen_phase == 3'd7)) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        if (gen_cic_ce) begin
          if (flush_q == FLUSH_LAST) begin
            state_d = CLEAR;
            clr_d   = '0;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= CLEAR;
      rate_q         <= RATE_9600;
      pend_q         <= RATE_9600;
      flush_q        <= '0;
      clr_q          <= '0;
      cfg_ready_q    <= 1'b0;
      busy_q         <= 1'b1;
      data_gate_q    <= 1'b1;
      cic_sync_rst_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      rate_q         <= rate_d;
      pend_q         <= pend_d;
      flush_q        <= flush_d;
      clr_q          <= clr_d;
      cfg_ready_q    <= (state_d == RUN);
      busy_q         <= (state_d != RUN);
      data_gate_q    <= (state_d == FLUSH) || (state_d == CLEAR);
      cic_sync_rst_q <= (state_d == CLEAR);
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign busy         = busy_q;
  assign data_gate    = data_gate_q;
  assign cic_sync_rst = cic_sync_rst_q;
  assign active_rate  = rate_q;
  assign cic_ce       = gen_cic_ce;
  assign filt_ce      = gen_filt_ce;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl: per-cycle reference model, hand
// sequences for rate-change corners, a vector table and random requests.
module tb_cic_rate_ctrl;
  import qam_pkg::*;

  localparam int BASE_DIV      = 18;
  localparam int FLUSH_SAMPLES = 16;
  localparam int CLEAR_CYCLES  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_rate = 2'b00;
  logic       cfg_ready, cic_ce, filt_ce, data_gate, cic_sync_rst, busy;
  logic [1:0] active_rate;
  state_e     dbg_state;

  always #5 clk = ~clk;

  cic_rate_ctrl #(
    .BASE_DIV     (BASE_DIV),
    .FLUSH_SAMPLES(FLUSH_SAMPLES),
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .PRE_W        (13)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_rate    (cfg_rate),
    .cfg_ready   (cfg_ready),
    .cic_ce      (cic_ce),
    .filt_ce     (filt_ce),
    .data_gate   (data_gate),
    .cic_sync_rst(cic_sync_rst),
    .active_rate (active_rate),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // Strobes are timed from the first RUN cycle (m_n=1): a strobe every
  // BASE_DIV*2^(3-rate) cycles, strobe number s has symbol phase (s-1)%8.
  state_e     m_st = CLEAR;
  int         m_n = 0, m_clr = 0, m_fl = 0;
  logic [1:0] m_rate = 2'b00, m_pend = 2'b00;
  logic       s_cic, s_filt, s_gate, s_srst, s_ready, s_busy;
  logic [1:0] s_rate;

  task automatic step();
    int p, s, ph;
    logic e_cic, e_filt, e_gate, e_srst, e_rdy, e_busy;
    state_e e_st;
    @(negedge clk);
    cyc++;
    e_cic = 0; e_filt = 0; e_gate = 1; e_srst = 1; e_rdy = 0; e_busy = 1; e_st = CLEAR;
    s = 0; ph = 0;
    if (!rst && m_st != CLEAR) begin
      p = BASE_DIV << (3 - int'(m_rate));
      e_cic = (m_n % p) == 0;
      s = m_n / p;
      ph = e_cic ? (s - 1) % 8 : 0;
      e_filt = e_cic && ph == 0 && m_st != FLUSH;
      e_gate = m_st == FLUSH;
      e_srst = 0;
      e_rdy = m_st == RUN;
      e_busy = m_st != RUN;
      e_st = m_st;
    end
    check("cic_ce", cic_ce, e_cic);
    check("filt_ce", filt_ce, e_filt);
    check("data_gate", data_gate, e_gate);
    check("cic_sync_rst", cic_sync_rst, e_srst);
    check("cfg_ready", cfg_ready, e_rdy);
    check("busy", busy, e_busy);
    check("active_rate", active_rate, rst ? 2'b00 : m_rate);
    check("state", 32'(dbg_state), 32'(e_st));
    s_cic = cic_ce; s_filt = filt_ce; s_gate = data_gate; s_srst = cic_sync_rst;
    s_ready = cfg_ready; s_busy = busy; s_rate = active_rate;
    if (rst) begin
      m_st = CLEAR; m_clr = 0; m_rate = 2'b00; m_pend = 2'b00;
    end else begin
      case (m_st)
        CLEAR: begin
          m_clr++;
          if (m_clr == CLEAR_CYCLES) begin m_st = RUN; m_n = 1; m_rate = m_pend; end
        end
        RUN: begin
          m_n++;
          if (cfg_valid && cfg_rate != m_rate) begin m_pend = cfg_rate; m_st = DRAIN; end
        end
        DRAIN: begin
          m_n++;
          if (e_cic && ph == 7) begin m_st = FLUSH; m_fl = 0; end
        end
        default: begin
          m_n++;
          if (e_cic) begin
            m_fl++;
            if (m_fl == FLUSH_SAMPLES) begin m_st = CLEAR; m_clr = 0; end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0: return s_cic;
      1: return s_filt;
      2: return s_gate;
      3: return s_ready;
      default: return !s_busy;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound, input string name, output int n);
    n = 0;
    do begin step(); n++; end while (!sig(sel) && n < bound);
    if (!sig(sel)) timeout(name);
  endtask

  task automatic request(input logic [1:0] r);
    cfg_valid = 1'b1;
    cfg_rate = r;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic reset_and_check_startup(input string tag);
    int n;
    repeat (3) step();
    rst = 1'b0;
    wait_for(0, 400, {tag, "_first_cic_to"}, n);
    check({tag, "_first_cic_cycle"}, n, 146);
    check({tag, "_first_cic_filt"}, s_filt, 1);
    check({tag, "_rate"}, s_rate, 2'b00);
    check({tag, "_ready"}, s_ready, 1);
    wait_for(0, 400, {tag, "_cic2_to"}, n);
    check({tag, "_cic_period"}, n, 144);
    wait_for(1, 2000, {tag, "_filt_to"}, n);
    check({tag, "_filt_gap"}, n, 1152 - 144);
  endtask

  typedef struct {
    logic [1:0] rate;
    int         settle;
    logic [1:0] exp_rate;
    logic       change;
  } vec_t;

  task automatic apply_vec(input vec_t v, input int idx);
    int n, busy_cnt;
    wait_for(3, 5000, "vec_ready_to", n);
    request(v.rate);
    busy_cnt = 0;
    repeat (v.settle) begin
      step();
      if (s_busy) busy_cnt++;
    end
    check($sformatf("vec%0d_active_rate", idx), s_rate, exp_q.pop_front());
    check($sformatf("vec%0d_busy_seen", idx), busy_cnt != 0, v.change);
    check($sformatf("vec%0d_busy_end", idx), s_busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[6];
    int n, g, fg, t0, t1, pre_cnt, hs, rises;
    logic prev_busy;

    vecs[0] = '{2'b00, 3600, 2'b00, 1'b1};
    vecs[1] = '{2'b10, 300,  2'b10, 1'b0};
    vecs[2] = '{2'b01, 3600, 2'b01, 1'b1};
    vecs[3] = '{2'b11, 3600, 2'b11, 1'b1};
    vecs[4] = '{2'b11, 300,  2'b11, 1'b0};
    vecs[5] = '{2'b00, 3600, 2'b00, 1'b1};
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_rate);

    // Reset release and startup cadence at 9600.
    reset_and_check_startup("startup");

    // 00 -> 11 from idle RUN: 16 gated strobes at the old spacing.
    request(2'b11);
    g = 0; fg = 0; t0 = 0; t1 = 0; n = 0;
    do begin
      step(); n++;
      if (s_cic && s_gate) begin
        g++;
        if (g == 1) t0 = cyc;
        if (g == 2) t1 = cyc;
      end
      if (s_filt && s_gate) fg++;
    end while (s_busy && n < 6000);
    if (s_busy) timeout("chg11_done_to");
    check("chg11_gated_strobes", g, 16);
    check("chg11_gated_spacing", t1 - t0, 144);
    check("chg11_filt_in_flush", fg, 0);
    check("chg11_active_rate", s_rate, 2'b11);
    wait_for(0, 200, "chg11_cic_to", n);
    wait_for(0, 200, "chg11_cic_to", n);
    check("chg11_cic_period", n, 18);
    wait_for(1, 400, "chg11_filt_to", n);
    wait_for(1, 400, "chg11_filt_to", n);
    check("chg11_filt_period", n, 144);

    // Back to 9600, then 00 -> 10 requested right after the phase-3 strobe.
    apply_vec(vecs[0], 0);
    wait_for(1, 2000, "mid_filt_to", n);
    repeat (3) wait_for(0, 400, "mid_cic_to", n);
    request(2'b10);
    pre_cnt = 0; n = 0;
    do begin
      step(); n++;
      if (s_cic && !s_gate) pre_cnt++;
    end while (!s_gate && n < 2000);
    if (!s_gate) timeout("mid_gate_to");
    check("mid_old_strobes", pre_cnt, 4);
    fg = 0; n = 0;
    do begin
      step(); n++;
      if (s_filt && s_gate) fg++;
    end while (s_busy && n < 4000);
    check("mid_filt_in_flush", fg, 0);
    wait_for(0, 200, "mid_cic_to", n);
    wait_for(0, 200, "mid_cic_to", n);
    check("mid_cic_period", n, 36);

    // Table: same-rate no-ops and further changes.
    for (int i = 1; i < 6; i++) apply_vec(vecs[i], i);

    // cfg_valid held through a change; the follow-up request lands on RUN entry.
    cfg_valid = 1'b1;
    cfg_rate = 2'b01;
    step();
    check("hold_first_hs", s_ready, 1);
    cfg_rate = 2'b10;
    hs = 0; n = 0; rises = 0; prev_busy = 0;
    do begin
      step(); n++;
      if (s_busy && !prev_busy) rises++;
      prev_busy = s_busy;
      if (s_ready) hs++;
    end while (hs == 0 && n < 6000);
    cfg_valid = 1'b0;
    if (hs == 0) timeout("hold_second_hs_to");
    check("hold_gap_nonzero", n > 100, 1);
    check("hold_second_rate", s_rate, 2'b01);
    n = 0;
    do begin
      step(); n++;
      if (s_busy && !prev_busy) rises++;
      prev_busy = s_busy;
    end while ((s_busy || n < 3) && n < 6000);
    check("hold_transactions", rises, 2);
    check("hold_final_rate", s_rate, 2'b10);

    // Asynchronous reset in the middle of a flush.
    request(2'b11);
    wait_for(2, 2000, "rst_flush_to", n);
    repeat (40) step();
    rst = 1'b1;
    #1;
    check("arst_data_gate", data_gate, 1);
    check("arst_sync_rst", cic_sync_rst, 1);
    check("arst_active_rate", active_rate, 2'b00);
    check("arst_cic_ce", cic_ce, 0);
    check("arst_cfg_ready", cfg_ready, 0);
    check("arst_busy", busy, 1);
    reset_and_check_startup("post_rst");

    // Random requests, cadence checked cycle by cycle by the model.
    for (int i = 0; i < 10; i++) begin
      cfg_rate = 2'($urandom_range(0, 3));
      cfg_valid = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      cfg_valid = 1'b0;
      repeat ($urandom_range(20, 2000)) step();
    end
    wait_for(4, 6000, "rand_settle_to", n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
Single-clock sequencer for the I/Q CIC x8 interpolator pair. It replaces muxed derived clocks with clock-enable strobes: cic_ce at 8x baud and filt_ce at baud, both derived from the system clock. It also handles safe baud-rate changes: wait for a symbol boundary, flush the CIC with zeros, hold it in reset, then resume at the new rate. It sits between the baud_rate configuration source and the shaping filter + CIC datapath.

Parameters:
BASE_DIV, 18, clk cycles per CIC sample at the fastest rate (76800x8)
FLUSH_SAMPLES, 16, zero-input CIC samples issued during a rate change
CLEAR_CYCLES, 2, clk cycles cic_sync_rst is held after flush or reset
PRE_W, 13, prescaler width; must satisfy 2^PRE_W > BASE_DIV

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  new-rate request
cfg_rate  in  2  requested rate: 00=9600, 01=19200, 10=38400, 11=76800
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
cic_ce  out  1  1-clk strobe, CIC sample enable (8x baud)
filt_ce  out  1  1-clk strobe, shaping-filter output fetch (baud); always coincides with a cic_ce
data_gate  out  1  1 = CIC input forced to zero
cic_sync_rst  out  1  synchronous reset to both CICs
active_rate  out  2  rate currently in effect
busy  out  1  high in any state except RUN

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- All outputs are driven from registers only; there is no combinational path from inputs to outputs.
- Reset values: cic_ce=0, filt_ce=0, data_gate=1, cic_sync_rst=1, active_rate=00, cfg_ready=0, busy=1, state=CLEAR, all counters 0.
- Counters:
  - pre counts 0..BASE_DIV-1 and wraps; tick when pre==BASE_DIV-1.
  - rcnt (3b) increments on tick.
  - k = 3 - active_rate.
  - cic_ce when tick && rcnt[k-1:0] is all ones (k=0 means every tick).
  - CIC period is BASE_DIV*2^k clk cycles: 144/72/36/18 for rates 00..11.
  - phase (3b) increments on cic_ce; filt_ce = cic_ce && phase==0.
- The first cic_ce after entering RUN occurs on the BASE_DIV*2^k-th clk cycle in RUN, counting the first RUN cycle as 1. That first cic_ce carries filt_ce.
- States:
  - CLEAR:
    - cic_sync_rst=1, data_gate=1, no strobes; pre/rcnt/phase held at 0.
    - Lasts CLEAR_CYCLES cycles, then -> RUN.
    - On exit, active_rate <= pending rate (00 after reset).
  - RUN:
    - Strobes free-running, data_gate=0, cfg_ready=1.
    - Accepted request with cfg_rate==active_rate: no-op, stay in RUN, cadence undisturbed.
    - Accepted request with a different rate: latch pending, -> DRAIN.
  - DRAIN:
    - cfg_ready=0, strobes continue at the old rate.
    - On the cic_ce with phase==7 (last sample of the current symbol) -> FLUSH, effective from the next cycle.
  - FLUSH:
    - data_gate=1, strobes continue at the old rate, filt_ce suppressed.
    - Count FLUSH_SAMPLES cic_ce; after the last one -> CLEAR.
- cfg_ready is deasserted outside RUN. A request held through DRAIN/FLUSH/CLEAR is accepted on the first RUN cycle.
- Async reset in any state returns immediately to reset values; any pending rate is discarded.
- Counter wrap is natural modulo 2^3 for rcnt/phase; pre never exceeds BASE_DIV-1.

Decomposition:
- Shared package (qam_pkg):
  - rate encodings RATE_9600..RATE_76800
  - state enum {CLEAR, RUN, DRAIN, FLUSH}
  - BASE_DIV default
  - function rate_to_k(rate) returning 3 - rate
- Sub-module cic_ce_gen:
  - contains pre/rcnt/phase, cic_ce, filt_ce
  - inputs: clear, run_en, k
- The FSM, handshake and flush counter stay in cic_rate_ctrl.

Test Plan:
1. Reset release, no cfg -> cic_sync_rst high 2 cycles, then RUN at rate 00; cic_ce every 144 clk, filt_ce every 1152 clk; first cic_ce (with filt_ce) on RUN cycle 144; cfg_ready=1, busy=0.
2. Request rate 11 from idle RUN -> DRAIN until phase-7 strobe; 16 gated strobes at 144-clk spacing (2304 clk); 2 clear cycles; then cic_ce every 18, filt_ce every 144; active_rate=11.
3. Request 00->10 mid-symbol (phase=3) -> 4 more old-rate strobes before data_gate rises; no filt_ce during FLUSH; new cic_ce period 36.
4. Request cfg_rate equal to active_rate -> single-cycle accept; data_gate, cic_sync_rst and busy stay 0; strobe timestamps unchanged.
5. cfg_valid held high through a change -> cfg_ready=0 in DRAIN/FLUSH/CLEAR; second request accepted on first RUN cycle; exactly one transaction per handshake.
6. Assert rst mid-FLUSH -> same-cycle reset values (data_gate=1, cic_sync_rst=1, active_rate=00); pending rate lost; after release, behaviour matches scenario 1.
